pcie_h2c_dsc_byp_ctrl: RTL and testbench

// - H2C counterpart of the fixed C2H bypass loader: drives XDMA H2C descriptor-bypass port from a host ring
//   of NR_SLOTS fixed-size slots, then forwards the resulting H2C AXIS data to user logic.
// - Tracks producer/consumer/done indices, bounds in-flight descriptors, checks beat count per slot.
// - Sits between pcie_*_bypass XDMA instance and LegoFPGA RX path, in the axi_aclk (user_clk_250) domain.

---
 rtl/pcie_h2c_dsc_byp_ctrl_if.sv | 42 ++++
 rtl/pcie_h2c_dsc_byp_ctrl.sv | 169 ++++++++++++++++
 tb/tb_pcie_h2c_dsc_byp_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pcie_h2c_dsc_byp_ctrl_if.sv
// Descriptor-bypass and H2C stream bundle for pcie_h2c_dsc_byp_ctrl.
// The master modport is the controller side; the slave modport is the XDMA and user-logic side.
interface pcie_h2c_dsc_byp_ctrl_if #(
  parameter int DATA_WIDTH = 256
);
  logic [63:0]             dsc_byp_src_addr;
  logic [63:0]             dsc_byp_dst_addr;
  logic [27:0]             dsc_byp_len;
  logic [15:0]             dsc_byp_ctl;
  logic                    dsc_byp_load;
  logic                    dsc_byp_ready;

  logic [DATA_WIDTH-1:0]   s_axis_h2c_tdata;
  logic [DATA_WIDTH/8-1:0] s_axis_h2c_tkeep;
  logic                    s_axis_h2c_tlast;
  logic                    s_axis_h2c_tvalid;
  logic                    s_axis_h2c_tready;

  logic [DATA_WIDTH-1:0]   m_axis_tdata;
  logic [DATA_WIDTH/8-1:0] m_axis_tkeep;
  logic                    m_axis_tlast;
  logic                    m_axis_tvalid;
  logic                    m_axis_tready;

  modport master (
    output dsc_byp_src_addr, dsc_byp_dst_addr, dsc_byp_len, dsc_byp_ctl, dsc_byp_load,
    input  dsc_byp_ready,
    input  s_axis_h2c_tdata, s_axis_h2c_tkeep, s_axis_h2c_tlast, s_axis_h2c_tvalid,
    output s_axis_h2c_tready,
    output m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tvalid,
    input  m_axis_tready
  );

  modport slave (
    input  dsc_byp_src_addr, dsc_byp_dst_addr, dsc_byp_len, dsc_byp_ctl, dsc_byp_load,
    output dsc_byp_ready,
    output s_axis_h2c_tdata, s_axis_h2c_tkeep, s_axis_h2c_tlast, s_axis_h2c_tvalid,
    input  s_axis_h2c_tready,
    input  m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tvalid,
    output m_axis_tready
  );
endinterface

// File: rtl/pcie_h2c_dsc_byp_ctrl.sv
// H2C descriptor-bypass loader: issues one fixed-size descriptor per host ring slot and forwards H2C data.
// Optional PCIE_H2C_STATS_EN adds free-running completed-slot and accepted-beat counters.
module pcie_h2c_dsc_byp_ctrl #(
  parameter int DATA_WIDTH      = 256,
  parameter int NR_SLOTS        = 16,
  parameter int SLOT_BYTES      = 4096,
  parameter int MAX_OUTSTANDING = 4,
  localparam int IDX_W          = $clog2(NR_SLOTS),
  localparam int OUT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                 clk,
  input  logic                 sys_rst,
  input  logic                 cfg_enable,
  input  logic [63:0]          cfg_ring_base,
  input  logic [IDX_W:0]       host_prod_idx,
  pcie_h2c_dsc_byp_ctrl_if.master bus,
  output logic [IDX_W:0]       cons_idx,
  output logic [IDX_W:0]       done_idx,
  output logic [OUT_W-1:0]     outstanding,
  output logic                 err_short,
  output logic                 err_long
`ifdef PCIE_H2C_STATS_EN
  ,
  output logic [31:0]          stat_pkts,
  output logic [47:0]          stat_beats
`endif
);

  localparam int BEAT_BYTES = DATA_WIDTH / 8;
  localparam int SLOT_BEATS = SLOT_BYTES / BEAT_BYTES;
  localparam int BEAT_W     = (SLOT_BEATS > 1) ? $clog2(SLOT_BEATS) : 1;

  localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(SLOT_BEATS - 1);
  localparam logic [IDX_W:0]    RING_DEPTH = (IDX_W + 1)'(NR_SLOTS);
  localparam logic [OUT_W-1:0]  OUT_MAX    = OUT_W'(MAX_OUTSTANDING);

  typedef enum logic {
    S_IDLE,
    S_LOAD
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [IDX_W:0]    pending;
  logic              issue_ok;
  logic              ld_src;
  logic              dsc_accept;
  logic [63:0]       src_addr_p0;

  logic              beat_acc;
  logic              in_slot;
  logic              at_last;
  logic              complete;
  logic [BEAT_W-1:0] beat_cnt;

  function automatic logic [63:0] slot_addr(input logic [63:0] base, input logic [IDX_W-1:0] slot);
    return base + (64'(slot) * 64'(SLOT_BYTES));
  endfunction

  // Ring occupancy; a difference beyond the ring depth means a bogus producer index and is not served.
  assign pending  = host_prod_idx - cons_idx;
  assign issue_ok = cfg_enable && (pending != '0) && (pending <= RING_DEPTH) &&
                    (outstanding < OUT_MAX);

  always_comb begin
    state_d = state_q;
    ld_src  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (issue_ok) begin
          state_d = S_LOAD;
          ld_src  = 1'b1;
        end
      end
      S_LOAD: begin
        if (bus.dsc_byp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Descriptor stage: address latched on entry to LOAD and frozen until the XDMA takes it.
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      src_addr_p0 <= '0;
    end else if (ld_src) begin
      src_addr_p0 <= slot_addr(cfg_ring_base, cons_idx[IDX_W-1:0]);
    end
  end

  assign dsc_accept           = (state_q == S_LOAD) && bus.dsc_byp_ready;
  assign bus.dsc_byp_load     = (state_q == S_LOAD);
  assign bus.dsc_byp_src_addr = src_addr_p0;
  assign bus.dsc_byp_dst_addr = 64'd0;
  assign bus.dsc_byp_len      = 28'(SLOT_BYTES);
  assign bus.dsc_byp_ctl      = 16'h0010;

  assign bus.m_axis_tdata      = bus.s_axis_h2c_tdata;
  assign bus.m_axis_tkeep      = bus.s_axis_h2c_tkeep;
  assign bus.m_axis_tlast      = bus.s_axis_h2c_tlast;
  assign bus.m_axis_tvalid     = bus.s_axis_h2c_tvalid;
  assign bus.s_axis_h2c_tready = bus.m_axis_tready;

  // A slot closes on tlast or on its final beat, whichever comes first; beats with nothing in flight are strays.
  assign beat_acc = bus.s_axis_h2c_tvalid && bus.m_axis_tready;
  assign in_slot  = (outstanding != '0);
  assign at_last  = (beat_cnt == LAST_BEAT);
  assign complete = beat_acc && in_slot && (bus.s_axis_h2c_tlast || at_last);

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      cons_idx    <= '0;
      done_idx    <= '0;
      outstanding <= '0;
      beat_cnt    <= '0;
      err_short   <= 1'b0;
      err_long    <= 1'b0;
    end else begin
      if (dsc_accept) begin
        cons_idx <= cons_idx + 1'b1;
      end
      if (complete) begin
        done_idx <= done_idx + 1'b1;
      end
      case ({dsc_accept, complete})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
      if (beat_acc && in_slot) begin
        beat_cnt <= complete ? '0 : beat_cnt + 1'b1;
      end
      if (complete && bus.s_axis_h2c_tlast && !at_last) begin
        err_short <= 1'b1;
      end
      if ((complete && at_last && !bus.s_axis_h2c_tlast) || (beat_acc && !in_slot)) begin
        err_long <= 1'b1;
      end
    end
  end

`ifdef PCIE_H2C_STATS_EN
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      stat_pkts  <= '0;
      stat_beats <= '0;
    end else begin
      if (complete) begin
        stat_pkts <= stat_pkts + 32'd1;
      end
      if (beat_acc) begin
        stat_beats <= stat_beats + 48'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pcie_h2c_dsc_byp_ctrl.sv
// Directed bench for pcie_h2c_dsc_byp_ctrl with descriptor and beat scoreboards.
module tb_pcie_h2c_dsc_byp_ctrl;
  localparam int DW   = 256;
  localparam int NS   = 16;
  localparam int SB   = 4096;
  localparam int MO   = 4;
  localparam int IW   = 4;
  localparam int OW   = 3;
  localparam int BEATS = SB / (DW / 8);
  localparam logic [63:0] BASE = 64'h1_0000_0000;

  logic clk = 1'b0;
  always #2 clk = ~clk;

  logic          sys_rst;
  logic          cfg_enable;
  logic [63:0]   cfg_ring_base;
  logic [IW:0]   host_prod_idx;
  logic [IW:0]   cons_idx;
  logic [IW:0]   done_idx;
  logic [OW-1:0] outstanding;
  logic          err_short;
  logic          err_long;
`ifdef PCIE_H2C_STATS_EN
  logic [31:0]   stat_pkts;
  logic [47:0]   stat_beats;
`endif

  pcie_h2c_dsc_byp_ctrl_if #(.DATA_WIDTH(DW)) bus ();

  pcie_h2c_dsc_byp_ctrl #(
    .DATA_WIDTH(DW), .NR_SLOTS(NS), .SLOT_BYTES(SB), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk(clk), .sys_rst(sys_rst), .cfg_enable(cfg_enable), .cfg_ring_base(cfg_ring_base),
    .host_prod_idx(host_prod_idx), .bus(bus), .cons_idx(cons_idx), .done_idx(done_idx),
    .outstanding(outstanding), .err_short(err_short), .err_long(err_long)
`ifdef PCIE_H2C_STATS_EN
    , .stat_pkts(stat_pkts), .stat_beats(stat_beats)
`endif
  );

  int n_vec = 0;
  int n_err = 0;
  logic [63:0]  dscq[$];
  logic [288:0] dq[$];
  logic [63:0]  dsc_exp;
  logic [288:0] beat_exp;
  logic         hold_prev;
  logic [63:0]  prev_src;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_slots(input int first, input int n);
    for (int i = 0; i < n; i++) dscq.push_back(BASE + 64'((first + i) % NS) * 64'h1000);
  endtask

  task automatic wait_cons(input logic [IW:0] tgt, input int budget);
    int k = 0;
    while (cons_idx !== tgt && k < budget) begin
      tick();
      k++;
    end
    @(negedge clk);
    chk("cons_idx", 64'(cons_idx), 64'(tgt));
    tick();
  endtask

  task automatic send_beats(input int n, input int last_at, input bit toggle);
    logic [DW-1:0] d;
    bit acc;
    int guard;
    for (int i = 0; i < n; i++) begin
      for (int w = 0; w < DW / 32; w++) d[w*32 +: 32] = $urandom();
      bus.s_axis_h2c_tdata  = d;
      bus.s_axis_h2c_tkeep  = '1;
      bus.s_axis_h2c_tlast  = (i == last_at);
      bus.s_axis_h2c_tvalid = 1'b1;
      dq.push_back({bus.s_axis_h2c_tlast, bus.s_axis_h2c_tkeep, d});
      guard = 0;
      do begin
        acc = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
        bus.m_axis_tready = acc;
        tick();
        guard++;
      end while (!acc && guard < 64);
    end
    bus.s_axis_h2c_tvalid = 1'b0;
    bus.s_axis_h2c_tlast  = 1'b0;
    bus.m_axis_tready     = 1'b1;
  endtask

  task automatic drain(input logic [IW:0] tgt, input int max_slots);
    int k = 0;
    int w;
    while (done_idx !== tgt && k < max_slots) begin
      w = 0;
      while (outstanding == '0 && w < 10) begin
        tick();
        w++;
      end
      send_beats(BEATS, BEATS - 1, 1'b0);
      k++;
    end
    @(negedge clk);
    chk("done_idx", 64'(done_idx), 64'(tgt));
    tick();
  endtask

  // Descriptor scoreboard and hold-stability checks.
  always @(negedge clk) begin
    if (sys_rst) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        chk("hold_load", 64'(bus.dsc_byp_load), 64'(1'b1));
        chk("hold_src", bus.dsc_byp_src_addr, prev_src);
      end
      if (bus.dsc_byp_load && bus.dsc_byp_ready) begin
        dsc_exp = (dscq.size() != 0) ? dscq.pop_front() : 64'hFFFF_FFFF_FFFF_FFFF;
        chk("dsc_src", bus.dsc_byp_src_addr, dsc_exp);
        chk("dsc_len", 64'(bus.dsc_byp_len), 64'h1000);
        chk("dsc_ctl", 64'(bus.dsc_byp_ctl), 64'h0010);
      end
      hold_prev = bus.dsc_byp_load && !bus.dsc_byp_ready;
      prev_src  = bus.dsc_byp_src_addr;
    end
  end

  // Beat scoreboard on the user-facing stream.
  always @(negedge clk) begin
    if (!sys_rst && bus.m_axis_tvalid) begin
      chk("s_tready", 64'(bus.s_axis_h2c_tready), 64'(bus.m_axis_tready));
      if (bus.m_axis_tready) begin
        beat_exp = (dq.size() != 0) ? dq.pop_front() : 'x;
        n_vec++;
        assert ({bus.m_axis_tlast, bus.m_axis_tkeep, bus.m_axis_tdata} === beat_exp) else begin
          n_err++;
          $error("FAIL beat: observed %h expected %h",
                 {bus.m_axis_tlast, bus.m_axis_tkeep, bus.m_axis_tdata}, beat_exp);
        end
      end
    end
  end

  initial begin
    sys_rst = 1'b1; cfg_enable = 1'b0; cfg_ring_base = BASE; host_prod_idx = '0;
    bus.dsc_byp_ready = 1'b1; bus.s_axis_h2c_tvalid = 1'b0; bus.s_axis_h2c_tdata = '0;
    bus.s_axis_h2c_tkeep = '0; bus.s_axis_h2c_tlast = 1'b0; bus.m_axis_tready = 1'b1;
    repeat (3) tick();
    sys_rst = 1'b0;
    @(negedge clk);
    chk("rst_load", 64'(bus.dsc_byp_load), 64'd0);
    chk("rst_src", bus.dsc_byp_src_addr, 64'd0);
    chk("rst_dst", bus.dsc_byp_dst_addr, 64'd0);
    chk("rst_len", 64'(bus.dsc_byp_len), 64'h1000);
    chk("rst_ctl", 64'(bus.dsc_byp_ctl), 64'h0010);
    chk("rst_cons", 64'(cons_idx), 64'd0);
    chk("rst_done", 64'(done_idx), 64'd0);
    chk("rst_out", 64'(outstanding), 64'd0);
    chk("rst_eshort", 64'(err_short), 64'd0);
    chk("rst_elong", 64'(err_long), 64'd0);
    tick();

    // Three loads from the ring base.
    cfg_enable = 1'b1;
    push_slots(0, 3);
    host_prod_idx = 5'd3;
    wait_cons(5'd3, 40);
    @(negedge clk);
    chk("out_3", 64'(outstanding), 64'd3);
    tick();

    // In-flight limit caps issue at four.
    push_slots(3, 5);
    host_prod_idx = 5'd8;
    wait_cons(5'd4, 40);
    repeat (20) tick();
    @(negedge clk);
    chk("cap_cons", 64'(cons_idx), 64'd4);
    chk("cap_out", 64'(outstanding), 64'd4);
    chk("cap_load", 64'(bus.dsc_byp_load), 64'd0);
    tick();

    // One full slot frees a credit for the fifth issue.
    send_beats(BEATS, BEATS - 1, 1'b0);
    wait_cons(5'd5, 20);
    @(negedge clk);
    chk("s1_done", 64'(done_idx), 64'd1);
    chk("s1_out", 64'(outstanding), 64'd4);
    chk("s1_eshort", 64'(err_short), 64'd0);
    chk("s1_elong", 64'(err_long), 64'd0);
    tick();

    // Ready held low while a descriptor is pending.
    bus.dsc_byp_ready = 1'b0;
    send_beats(BEATS, BEATS - 1, 1'b0);
    repeat (12) tick();
    @(negedge clk);
    chk("stall_load", 64'(bus.dsc_byp_load), 64'd1);
    chk("stall_src", bus.dsc_byp_src_addr, BASE + 64'h5000);
    chk("stall_done", 64'(done_idx), 64'd2);
    chk("stall_out", 64'(outstanding), 64'd3);
    tick();
    bus.dsc_byp_ready = 1'b1;
    wait_cons(5'd6, 10);
    @(negedge clk);
    chk("stall_out4", 64'(outstanding), 64'd4);
    tick();

    // Short slot then long slot.
    send_beats(64, 63, 1'b0);
    @(negedge clk);
    chk("short_err", 64'(err_short), 64'd1);
    chk("short_elong", 64'(err_long), 64'd0);
    chk("short_done", 64'(done_idx), 64'd3);
    tick();
    wait_cons(5'd7, 20);
    send_beats(BEATS, -1, 1'b0);
    @(negedge clk);
    chk("long_err", 64'(err_long), 64'd1);
    chk("long_done", 64'(done_idx), 64'd4);
    tick();
    wait_cons(5'd8, 20);
    drain(5'd8, 6);
    @(negedge clk);
    chk("d8_out", 64'(outstanding), 64'd0);
    chk("d8_dscq", 64'(dscq.size()), 64'd0);
    tick();

    // Reset clears sticky errors and indices.
    sys_rst = 1'b1;
    host_prod_idx = '0;
    repeat (3) tick();
    sys_rst = 1'b0;
    @(negedge clk);
    chk("rst2_eshort", 64'(err_short), 64'd0);
    chk("rst2_elong", 64'(err_long), 64'd0);
    chk("rst2_cons", 64'(cons_idx), 64'd0);
    chk("rst2_done", 64'(done_idx), 64'd0);
    tick();

    // Bogus producer index and disabled issue.
    host_prod_idx = 5'd17;
    repeat (20) tick();
    @(negedge clk);
    chk("bogus_cons", 64'(cons_idx), 64'd0);
    chk("bogus_load", 64'(bus.dsc_byp_load), 64'd0);
    tick();
    cfg_enable = 1'b0;
    host_prod_idx = 5'd2;
    repeat (20) tick();
    @(negedge clk);
    chk("dis_cons", 64'(cons_idx), 64'd0);
    tick();
    cfg_enable = 1'b1;
    push_slots(0, 2);
    wait_cons(5'd2, 20);
    send_beats(BEATS, BEATS - 1, 1'b1);
    send_beats(BEATS, BEATS - 1, 1'b1);
    @(negedge clk);
    chk("tog_done", 64'(done_idx), 64'd2);
    chk("tog_out", 64'(outstanding), 64'd0);
`ifdef PCIE_H2C_STATS_EN
    chk("stat_pkts", 64'(stat_pkts), 64'd2);
    chk("stat_beats", 64'(stat_beats), 64'd256);
`endif
    tick();

    // Walk the indices across the ring and wrap bit.
    push_slots(2, 13);
    host_prod_idx = 5'd15;
    drain(5'd15, 20);
    wait_cons(5'd15, 20);
    push_slots(15, 3);
    host_prod_idx = 5'd18;
    wait_cons(5'd18, 40);
    drain(5'd18, 6);
    push_slots(2, 14);
    host_prod_idx = 5'd0;
    drain(5'd0, 20);
    @(negedge clk);
    chk("wrap_cons", 64'(cons_idx), 64'd0);
    chk("wrap_out", 64'(outstanding), 64'd0);
    chk("wrap_dscq", 64'(dscq.size()), 64'd0);
    chk("wrap_elong", 64'(err_long), 64'd0);
    chk("wrap_eshort", 64'(err_short), 64'd0);
    tick();

    // Stray beat with nothing in flight.
    send_beats(1, -1, 1'b0);
    @(negedge clk);
    chk("stray_elong", 64'(err_long), 64'd1);
    chk("stray_done", 64'(done_idx), 64'd0);
    chk("stray_out", 64'(outstanding), 64'd0);
    chk("stray_dq", 64'(dq.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
